// File: rtl/spi_slave_regfile.sv
// Mode-0 SPI slave with an 8-bit register bank, oversampled in the aclk domain.
// 16-bit frames: {rnw, addr[6:0], data[7:0]}; reg 0 is a read-only ID.
module spi_slave_regfile #(
    parameter int          REG_COUNT = 16,
    parameter logic [7:0]  ID_VALUE  = 8'hA5,
    localparam int         AW        = $clog2(REG_COUNT)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          spi_cs,
    input  logic          spi_sclk,
    input  logic          spi_mosi,
    output logic          spi_miso,
    input  logic [AW-1:0] loc_addr,
    output logic [7:0]    loc_rdata,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          frame_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    localparam logic [7:0] RC8 = 8'(REG_COUNT);

    state_t      state_q, state_d;
    logic        cs_s1, cs_s2, cs_s3;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        mosi_s1, mosi_s2;
    logic [3:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [7:0]  tx_q;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic        hold_q;
    logic [7:0]  regs [REG_COUNT];

    logic        cs_fall, cs_rise, rise, fall;
    logic        start, cmd_done, data_done, abort, commit;
    logic [7:0]  rx_byte;

    // CS sync flops reset low so a CS already low at reset release never looks like a new frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            {cs_s1, cs_s2, cs_s3}       <= '0;
            {sclk_s1, sclk_s2, sclk_s3} <= '0;
            {mosi_s1, mosi_s2}          <= '0;
        end else begin
            {cs_s3, cs_s2, cs_s1}       <= {cs_s2, cs_s1, spi_cs};
            {sclk_s3, sclk_s2, sclk_s1} <= {sclk_s2, sclk_s1, spi_sclk};
            {mosi_s2, mosi_s1}          <= {mosi_s1, spi_mosi};
        end
    end

    assign cs_fall = cs_s3 & ~cs_s2;
    assign cs_rise = ~cs_s3 & cs_s2;
    assign rise    = ~cs_s2 & sclk_s2 & ~sclk_s3;
    assign fall    = ~cs_s2 & ~sclk_s2 & sclk_s3;
    assign rx_byte = {shift_q, mosi_s2};

    function automatic logic addr_ok(input logic [6:0] a);
        return (a != 7'd0) && ({1'b0, a} < RC8);
    endfunction

    function automatic logic [7:0] rd_val(input logic [6:0] a);
        if (a == 7'd0)             return ID_VALUE;
        else if ({1'b0, a} < RC8)  return regs[a[AW-1:0]];
        else                       return 8'h00;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        cmd_done  = 1'b0;
        data_done = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                state_d = CMD;
                start   = 1'b1;
            end
            CMD: if (cs_rise) begin
                state_d = IDLE;
                abort   = 1'b1;
            end else if (rise && bit_cnt == 4'd7) begin
                state_d  = DATA;
                cmd_done = 1'b1;
            end
            DATA: if (cs_rise) begin
                state_d = IDLE;
                abort   = 1'b1;
            end else if (rise && bit_cnt == 4'd15) begin
                state_d   = DONE;
                data_done = 1'b1;
            end
            DONE: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign commit = data_done & ~rw_q & addr_ok(addr_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            hold_q    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            loc_rdata <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= abort;
            loc_rdata <= rd_val(7'(loc_addr));
            if (start) begin
                bit_cnt <= '0;
                shift_q <= '0;
                tx_q    <= '0;
                hold_q  <= 1'b0;
            end else if (rise && (state_q == CMD || state_q == DATA)) begin
                bit_cnt <= bit_cnt + 4'd1;
                shift_q <= {shift_q[5:0], mosi_s2};
            end
            if (cmd_done) begin
                rw_q   <= rx_byte[7];
                addr_q <= rx_byte[6:0];
                hold_q <= 1'b1;
                if (rx_byte[7]) tx_q <= rd_val(rx_byte[6:0]);
            end
            // The first fall after the command byte keeps bit 7 up for the 9th rise.
            if (fall && state_q == DATA) begin
                if (hold_q) hold_q <= 1'b0;
                else        tx_q   <= {tx_q[6:0], 1'b0};
            end
            if (commit) begin
                regs[addr_q[AW-1:0]] <= rx_byte;
                wr_valid             <= 1'b1;
                wr_addr              <= addr_q[AW-1:0];
                wr_data              <= rx_byte;
            end
        end
    end

    assign spi_miso = (state_q == DATA) & tx_q[7];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: bit-banged SPI frames, write scoreboard, MISO capture.
module tb_spi_slave_regfile;

    localparam int AW = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          spi_cs, spi_sclk, spi_mosi;
    logic          spi_miso;
    logic [AW-1:0] loc_addr;
    logic [7:0]    loc_rdata;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_err;

    int total = 0;
    int bad   = 0;
    int unexp_cnt = 0;
    int err_cnt   = 0;
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;
    logic [31:0] rx;

    spi_slave_regfile #(.REG_COUNT(16), .ID_VALUE(8'hA5)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .loc_addr(loc_addr), .loc_rdata(loc_rdata),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Shifts nbits of word MSB first; MISO sampled just before each rising sclk.
    task automatic xfer(input logic [31:0] word, input int nbits, input bit end_cs,
                        output logic [31:0] rxo);
        rxo = '0;
        spi_cs = 1'b0;
        wait_clk(8);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = word[i];
            wait_clk(8);
            rxo = {rxo[30:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(8);
            spi_sclk = 1'b0;
        end
        wait_clk(8);
        if (end_cs) spi_cs = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(16);
    endtask

    // Write scoreboard: every wr_valid must match the oldest expected write.
    always @(negedge aclk) begin
        if (wr_valid) begin
            if (exp_q.size() == 0) unexp_cnt++;
            else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(mon_e[11:8]));
                chk("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
            end
        end
        if (frame_err) err_cnt++;
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_miso"},  32'(spi_miso),  0);
        chk({tag, "_wrv"},   32'(wr_valid),  0);
        chk({tag, "_ferr"},  32'(frame_err), 0);
        chk({tag, "_wra"},   32'(wr_addr),   0);
        chk({tag, "_wrd"},   32'(wr_data),   0);
        chk({tag, "_rdata"}, 32'(loc_rdata), 0);
    endtask

    task automatic chk_reg(input string tag, input logic [AW-1:0] a, input logic [7:0] v);
        loc_addr = a;
        wait_clk(2);
        chk(tag, 32'(loc_rdata), 32'(v));
    endtask

    initial begin
        aresetn = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; loc_addr = '0;
        wait_clk(3);
        chk_zero_outputs("rst");
        aresetn = 1'b1;
        wait_clk(5);
        chk("id_local", 32'(loc_rdata), 32'hA5);

        // Plain write to reg 3
        exp_q.push_back({4'd3, 8'h5A});
        xfer(32'h035A, 16, 1'b1, rx);
        chk("wr3_drain", 32'(exp_q.size()), 0);
        chk("wr3_miso", rx, 0);
        chk_reg("reg3", 4'd3, 8'h5A);

        // Reads: reg 3, ID, out-of-range addr 16
        xfer(32'h8300, 16, 1'b1, rx);
        chk("rd3_miso", rx, 32'h005A);
        xfer(32'h8000, 16, 1'b1, rx);
        chk("rd_id_miso", rx, 32'h00A5);
        xfer(32'h00FF, 16, 1'b1, rx);
        chk_reg("reg0_ro", 4'd0, 8'hA5);
        chk("wr0_ignored", 32'(unexp_cnt), 0);
        xfer(32'h9000, 16, 1'b1, rx);
        chk("rd_oor_miso", rx, 0);

        // CS abort after 12 bits of write 0x05,0x77
        xfer(32'h057, 12, 1'b1, rx);
        chk("abort_ferr", 32'(err_cnt), 1);
        chk("abort_nowr", 32'(unexp_cnt), 0);
        chk_reg("abort_reg5", 4'd5, 8'h00);
        exp_q.push_back({4'd5, 8'h11});
        xfer(32'h0511, 16, 1'b1, rx);
        chk("post_abort_drain", 32'(exp_q.size()), 0);
        chk_reg("post_abort_reg5", 4'd5, 8'h11);

        // 20 sclk cycles in one CS window
        exp_q.push_back({4'd2, 8'h33});
        xfer(32'h02330, 20, 1'b1, rx);
        chk("long_miso", rx, 0);
        chk("long_drain", 32'(exp_q.size()), 0);
        chk("long_nodup", 32'(unexp_cnt), 0);
        chk_reg("long_reg2", 4'd2, 8'h33);

        // Reset in the data byte with CS held low
        loc_addr = 4'd3;
        xfer(32'h064, 12, 1'b0, rx);
        aresetn = 1'b0;
        wait_clk(2);
        chk_zero_outputs("midrst");
        aresetn = 1'b1;
        wait_clk(4);
        xfer(32'h44, 8, 1'b1, rx);
        chk("midrst_nowr", 32'(unexp_cnt), 0);
        chk("midrst_noferr", 32'(err_cnt), 1);
        chk_reg("midrst_reg3", 4'd3, 8'h00);
        chk_reg("midrst_reg6", 4'd6, 8'h00);
        exp_q.push_back({4'd6, 8'h44});
        xfer(32'h0644, 16, 1'b1, rx);
        chk("fresh_drain", 32'(exp_q.size()), 0);
        chk_reg("fresh_reg6", 4'd6, 8'h44);
        chk("final_unexp", 32'(unexp_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
